seven_seg_scan_ctrl: RTL

Time-multiplexing scan controller for a common-segment, multi-digit seven-segment display. It sits ahead of the team's combinational 4-bit hex-to-seven-segment decoder and shares that single decoder across `NUM_DIGITS` digits. Each scan cycle it presents one nibble on `nibble_out` and enables the matching digit driver. It also handles atomic frame-boundary value updates, anti-ghosting dead time and optional leading-zero blanking.

---
 rtl/seven_seg_scan_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed scan controller for a shared hex-to-7seg decoder
// Outputs are registered; next-cycle values are computed from next-state counters (lookahead).
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int TICK_DIV     = 50000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   input  logic                    lz_blank,
   output logic [3:0]              nibble_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    update_pending,
   output logic                    frame_start
);

   localparam int SW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [SW-1:0] SLOT_LAST = SW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SLOT_SHOW = SW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   typedef enum logic {PH_BLANK, PH_SHOW} phase_e;

   logic [SW-1:0]             slot_cnt_q, slot_cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
   logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
   logic                      pending_q, pending_d;
   logic                      lz_slot_q, lz_slot_d;
   logic [3:0]                nibble_q, nibble_d;
   logic [NUM_DIGITS-1:0]     digit_en_q, digit_en_d;
   logic                      frame_start_q, frame_start_d;

   phase_e                    phase_d;
   logic                      slot_last;
   logic                      commit;
   logic                      zero_above;
   logic [NUM_DIGITS-1:0]     lead_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q    <= '0;
         idx_q         <= '0;
         shadow_q      <= '0;
         disp_q        <= '0;
         pending_q     <= 1'b0;
         lz_slot_q     <= 1'b0;
         nibble_q      <= '0;
         digit_en_q    <= '0;
         frame_start_q <= 1'b0;
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         disp_q        <= disp_d;
         pending_q     <= pending_d;
         lz_slot_q     <= lz_slot_d;
         nibble_q      <= nibble_d;
         digit_en_q    <= digit_en_d;
         frame_start_q <= frame_start_d;
      end
   end

   always_comb begin
      slot_last  = (slot_cnt_q == SLOT_LAST);
      slot_cnt_d = slot_last ? '0 : slot_cnt_q + SW'(1);
      idx_d      = idx_q;
      if (slot_last) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end

      // Commit uses the pre-load shadow, so a load on the commit edge waits a frame.
      commit    = pending_q && slot_last && (idx_q == IDX_LAST);
      disp_d    = commit ? shadow_q : disp_q;
      shadow_d  = load ? value_in : shadow_q;
      pending_d = load ? 1'b1 : (commit ? 1'b0 : pending_q);

      phase_d   = (slot_cnt_d < SLOT_SHOW) ? PH_BLANK : PH_SHOW;
      lz_slot_d = (slot_cnt_d == SLOT_SHOW) ? lz_blank : lz_slot_q;

      zero_above = 1'b1;
      lead_zero  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above   = zero_above && (disp_d[4*i +: 4] == 4'h0);
         lead_zero[i] = zero_above;
      end

      nibble_d   = '0;
      digit_en_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == idx_d) begin
            nibble_d = disp_d[4*i +: 4];
            if (phase_d == PH_SHOW && !(lz_slot_d && lead_zero[i] && i != 0)) begin
               digit_en_d[i] = 1'b1;
            end
         end
      end

      // Reset value 0 covers the no-pulse-on-cycle-0 rule.
      frame_start_d = (slot_cnt_d == '0) && (idx_d == '0);
   end

   assign nibble_out     = nibble_q;
   assign digit_en       = digit_en_q;
   assign update_pending = pending_q;
   assign frame_start    = frame_start_q;

endmodule
